spu_host_seq: RTL and testbench

Host-side sequencer for the SPU. It accepts single-word commands from a host port: load an instruction word, write a data word, read a data word, or run the program. It writes instruction memory directly and owns the data-memory port except while the SPU runs. During a run it pulses `start`, hands data memory to the core, waits for `stop` and reports completion.

---
 rtl/spu_host_seq.sv | 125 ++++++++++++
 tb/tb_spu_host_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_host_seq.sv
// spu_host_seq: host command sequencer that loads IM/DM, reads DM and runs the SPU
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   cmd_valid/cmd_ready   host command handshake; cmd_op 00 IM wr, 01 DM wr, 10 run, 11 DM rd
//   cmd_addr, cmd_data    command address and write data, registered on accept
//   rsp_valid, rsp_data   DM read response pulse; rsp_data holds until the next read
//   busy, done, timeout   not idle / run ended by stop / run aborted by the watchdog
//   im_w_addr/data, im_wr instruction memory write port
//   spu_start, spu_stop   SPU run handshake; spu_rst resets the SPU
//   spu_dm_*              SPU data-memory request, forwarded only during START/RUN
//   mem_dm_*              data memory port, read data one cycle after mem_dm_rd
// Build option: define SPU_WDOG_EN to abort runs longer than WDOG_CYC RUN cycles.
module spu_host_seq #(
    parameter int unsigned WDOG_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  im_w_addr,
    output logic [15:0] im_w_data,
    output logic        im_wr,
    output logic        spu_start,
    input  logic        spu_stop,
    output logic        spu_rst,
    input  logic [7:0]  spu_dm_addr,
    input  logic        spu_dm_rd,
    input  logic        spu_dm_wr,
    input  logic [15:0] spu_dm_w_data,
    output logic [7:0]  mem_dm_addr,
    output logic        mem_dm_rd,
    output logic        mem_dm_wr,
    output logic [15:0] mem_dm_w_data,
    input  logic [15:0] mem_dm_r_data
);
    typedef enum logic [2:0] {IDLE, IMWR, DMWR, DMRD, DMRSP, START, RUN, DONE} state_t;
    state_t      state;
    logic [7:0]  addr_q;
    logic [15:0] data_q, rsp_q;
    logic        rd_q, wr_q, first_q, accept, stop_hit, wdog_hit, spu_owns;
    assign cmd_ready = (state == IDLE) & !rst;
    assign busy      = state != IDLE;
    assign accept    = cmd_valid & cmd_ready;
    // stop is still high from the previous run during the first RUN cycle
    assign stop_hit  = (state == RUN) & !first_q & spu_stop;
    assign spu_owns  = (state == START) | (state == RUN);
    assign im_w_addr = addr_q;
    assign im_w_data = data_q;
    assign mem_dm_addr   = spu_owns ? spu_dm_addr   : addr_q;
    assign mem_dm_rd     = spu_owns ? spu_dm_rd     : rd_q;
    assign mem_dm_wr     = spu_owns ? spu_dm_wr     : wr_q;
    assign mem_dm_w_data = spu_owns ? spu_dm_w_data : data_q;
    // read data arrives in DMRSP, so it is forwarded then and held afterwards
    assign rsp_data = (state == DMRSP) ? mem_dm_r_data : rsp_q;
`ifdef SPU_WDOG_EN
    logic [31:0] wcnt;
    logic        abort_q, timeout_q;
    assign wdog_hit = (state == RUN) & !stop_hit & (wcnt + 32'd1 == WDOG_CYC);
    assign timeout  = timeout_q;
    assign spu_rst  = rst | abort_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt      <= '0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wcnt      <= (state == START) ? '0 : (state == RUN) ? wcnt + 32'd1 : wcnt;
            abort_q   <= wdog_hit;
            timeout_q <= wdog_hit;
        end
    end
`else
    logic [31:0] unused_wdog;
    assign unused_wdog = WDOG_CYC;
    assign wdog_hit    = 1'b0;
    assign timeout     = 1'b0;
    assign spu_rst     = rst;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            rsp_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            first_q   <= 1'b0;
            im_wr     <= 1'b0;
            spu_start <= 1'b0;
            rsp_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            im_wr     <= accept & (cmd_op == 2'b00);
            wr_q      <= accept & (cmd_op == 2'b01);
            spu_start <= accept & (cmd_op == 2'b10);
            rd_q      <= accept & (cmd_op == 2'b11);
            rsp_valid <= state == DMRD;
            done      <= stop_hit;
            first_q   <= state == START;
            if (accept) begin
                addr_q <= cmd_addr;
                data_q <= cmd_data;
            end
            if (state == DMRSP) rsp_q <= mem_dm_r_data;
            case (state)
                IDLE:    state <= !accept ? IDLE :
                                  cmd_op == 2'b00 ? IMWR :
                                  cmd_op == 2'b01 ? DMWR :
                                  cmd_op == 2'b11 ? DMRD : START;
                DMRD:    state <= DMRSP;
                START:   state <= RUN;
                RUN:     state <= stop_hit ? DONE : wdog_hit ? IDLE : RUN;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spu_host_seq.sv
// tb_spu_host_seq: randomized self-checking bench for spu_host_seq with a DM model and scoreboard
module tb_spu_host_seq;
    localparam int W = 50;
    logic        clk = 0, rst = 1, cmd_valid = 0, spu_stop = 1;
    logic [1:0]  cmd_op = 0;
    logic [7:0]  cmd_addr = 0, spu_dm_addr = 0;
    logic [15:0] cmd_data = 0, spu_dm_w_data = 0;
    logic        spu_dm_rd = 0, spu_dm_wr = 0;
    logic        cmd_ready, rsp_valid, busy, done, timeout, im_wr, spu_start, spu_rst;
    logic        mem_dm_rd, mem_dm_wr;
    logic [15:0] rsp_data, im_w_data, mem_dm_w_data, mem_dm_r_data;
    logic [7:0]  im_w_addr, mem_dm_addr;
    logic [15:0] mem [256];
    logic [15:0] mem_rd_q = 0;
    logic        mem_clr = 0;
    logic [15:0] ref_dm [256];
    int          wr_count = 0;
    int          tests = 0, fails = 0;

    spu_host_seq #(.WDOG_CYC(W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .done(done), .timeout(timeout), .im_w_addr(im_w_addr),
        .im_w_data(im_w_data), .im_wr(im_wr), .spu_start(spu_start), .spu_stop(spu_stop),
        .spu_rst(spu_rst), .spu_dm_addr(spu_dm_addr), .spu_dm_rd(spu_dm_rd),
        .spu_dm_wr(spu_dm_wr), .spu_dm_w_data(spu_dm_w_data), .mem_dm_addr(mem_dm_addr),
        .mem_dm_rd(mem_dm_rd), .mem_dm_wr(mem_dm_wr), .mem_dm_w_data(mem_dm_w_data),
        .mem_dm_r_data(mem_dm_r_data)
    );

    always #5 clk = ~clk;
    assign mem_dm_r_data = mem_rd_q;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_dm_wr === 1'b1) begin
            mem[mem_dm_addr] <= mem_dm_w_data;
        end
        if (mem_dm_wr === 1'b1) wr_count <= wr_count + 1;
        if (mem_dm_rd === 1'b1) mem_rd_q <= mem[mem_dm_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; mem_clr = 1; cmd_valid = 1; cmd_op = 2'b00;
        tick(); tick();
        mem_clr = 0;
        tests++;
        if ({cmd_ready, rsp_valid, done, timeout, im_wr, mem_dm_rd, mem_dm_wr, spu_start, busy} !== 9'b0) begin
            fails++;
            $display("FAIL reset_pulses got %b%b%b%b%b%b%b%b%b exp 000000000", cmd_ready, rsp_valid,
                     done, timeout, im_wr, mem_dm_rd, mem_dm_wr, spu_start, busy);
        end
        tests++;
        if ({rsp_data, im_w_addr, im_w_data} !== 40'h0) begin
            fails++;
            $display("FAIL reset_data got rsp=%h ima=%h imd=%h exp 0", rsp_data, im_w_addr, im_w_data);
        end
        tests++;
        if (spu_rst !== 1'b1) begin
            fails++;
            $display("FAIL reset_spu_rst got %b exp 1", spu_rst);
        end
        cmd_valid = 0; rst = 0; #1;
        tests++;
        if ({cmd_ready, spu_rst, busy} !== 3'b100) begin
            fails++;
            $display("FAIL reset_release got ready=%b spu_rst=%b busy=%b exp 1 0 0", cmd_ready, spu_rst, busy);
        end
    endtask

    task automatic test_im_write();
        logic [7:0] a;
        logic [15:0] d;
        for (int i = 0; i < 8; i++) begin
            a = (i == 0) ? 8'h05 : 8'($urandom);
            d = (i == 0) ? 16'hA1B2 : 16'($urandom);
            cmd_valid = 1; cmd_op = 2'b00; cmd_addr = a; cmd_data = d; #1;
            tests++;
            if (cmd_ready !== 1'b1) begin
                fails++;
                $display("FAIL im_ready_pre i=%0d got %b exp 1", i, cmd_ready);
            end
            tick();
            cmd_valid = 0; cmd_addr = 8'($urandom); cmd_data = 16'($urandom); #1;
            tests++;
            if ({im_wr, im_w_addr, im_w_data, cmd_ready} !== {1'b1, a, d, 1'b0}) begin
                fails++;
                $display("FAIL im_strobe i=%0d got wr=%b a=%h d=%h rdy=%b exp 1 %h %h 0",
                         i, im_wr, im_w_addr, im_w_data, cmd_ready, a, d);
            end
            tick();
            tests++;
            if ({im_wr, cmd_ready} !== 2'b01) begin
                fails++;
                $display("FAIL im_after i=%0d got wr=%b rdy=%b exp 0 1", i, im_wr, cmd_ready);
            end
        end
    endtask

    task automatic test_dm_rw(input int n);
        logic [7:0] a;
        logic [15:0] d;
        bit wr;
        for (int i = 0; i < n; i++) begin
            wr = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            a = (i < 2) ? 8'h10 : 8'($urandom_range(0, 7));
            d = (i == 0) ? 16'h1234 : 16'($urandom);
            spu_dm_addr = 8'($urandom); spu_dm_rd = 1; spu_dm_wr = 1; spu_dm_w_data = 16'($urandom);
            cmd_valid = 1; cmd_op = wr ? 2'b01 : 2'b11; cmd_addr = a; cmd_data = d; #1;
            tests++;
            if ({cmd_ready, mem_dm_rd, mem_dm_wr} !== 3'b100) begin
                fails++;
                $display("FAIL dm_idle i=%0d got rdy=%b rd=%b wr=%b exp 1 0 0", i, cmd_ready, mem_dm_rd, mem_dm_wr);
            end
            tick();
            cmd_valid = 0; cmd_addr = 8'($urandom); cmd_data = 16'($urandom); #1;
            if (wr) begin
                tests++;
                if ({mem_dm_wr, mem_dm_rd, mem_dm_addr, mem_dm_w_data, cmd_ready} !== {2'b10, a, d, 1'b0}) begin
                    fails++;
                    $display("FAIL dm_write i=%0d got wr=%b rd=%b a=%h d=%h rdy=%b exp 1 0 %h %h 0",
                             i, mem_dm_wr, mem_dm_rd, mem_dm_addr, mem_dm_w_data, cmd_ready, a, d);
                end
                ref_dm[a] = d;
                tick();
                tests++;
                if ({mem_dm_wr, cmd_ready} !== 2'b01) begin
                    fails++;
                    $display("FAIL dm_write_end i=%0d got wr=%b rdy=%b exp 0 1", i, mem_dm_wr, cmd_ready);
                end
            end else begin
                tests++;
                if ({mem_dm_rd, mem_dm_wr, mem_dm_addr, rsp_valid, busy} !== {2'b10, a, 2'b01}) begin
                    fails++;
                    $display("FAIL dm_read_strobe i=%0d got rd=%b wr=%b a=%h rv=%b busy=%b exp 1 0 %h 0 1",
                             i, mem_dm_rd, mem_dm_wr, mem_dm_addr, rsp_valid, busy, a);
                end
                tick();
                tests++;
                if ({rsp_valid, rsp_data, cmd_ready} !== {1'b1, ref_dm[a], 1'b0}) begin
                    fails++;
                    $display("FAIL dm_read_rsp i=%0d got rv=%b data=%h rdy=%b exp 1 %h 0",
                             i, rsp_valid, rsp_data, cmd_ready, ref_dm[a]);
                end
                tick();
                tests++;
                if ({rsp_valid, rsp_data, cmd_ready} !== {1'b0, ref_dm[a], 1'b1}) begin
                    fails++;
                    $display("FAIL dm_read_hold i=%0d got rv=%b data=%h rdy=%b exp 0 %h 1",
                             i, rsp_valid, rsp_data, cmd_ready, ref_dm[a]);
                end
            end
        end
        spu_dm_rd = 0; spu_dm_wr = 0;
    endtask

    // rise: RUN-relative offset where spu_stop comes back (0 = never); bp: hold a DM write during the run
    task automatic run_seq(input int rise, input bit bp);
        int t_to, t_done, idle_off, wc0;
        bit pass, exp_busy;
        logic [7:0] ba;
        logic [15:0] bd;
`ifdef SPU_WDOG_EN
        t_to = (rise == 0 || rise - 1 > W) ? W + 2 : 0;
`else
        t_to = 0;
`endif
        t_done = (t_to != 0) ? 0 : rise + 1;
        idle_off = (t_to != 0) ? t_to : t_done + 1;
        ba = 8'($urandom_range(0, 7)); bd = 16'($urandom);
        spu_stop = 1; cmd_op = 2'b10; cmd_valid = 1; #1;
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL run_accept got rdy=%b exp 1", cmd_ready);
        end
        tick();
        cmd_valid = 0; wc0 = wr_count;
        for (int off = 1; off <= idle_off + 1; off++) begin
            spu_stop = (off <= 2) || (rise != 0 && off >= rise);
            spu_dm_addr = 8'($urandom_range(0, 7)); spu_dm_w_data = 16'($urandom);
            spu_dm_rd = 1'($urandom); spu_dm_wr = bp ? 1'b0 : 1'($urandom);
            if (bp) begin
                cmd_valid = (off >= 3) && (off <= idle_off);
                cmd_op = 2'b01; cmd_addr = ba; cmd_data = bd;
            end
            #1;
            pass = off < ((t_to != 0) ? t_to : t_done);
            exp_busy = (off < idle_off) || (bp && off == idle_off + 1);
            tests++;
            if ({spu_start, done, timeout, spu_rst, busy, cmd_ready} !==
                {off == 1, off == t_done, off == t_to, off == t_to, exp_busy, !exp_busy}) begin
                fails++;
                $display("FAIL run_ctl rise=%0d off=%0d got st=%b dn=%b to=%b sr=%b busy=%b rdy=%b exp %b %b %b %b %b %b",
                         rise, off, spu_start, done, timeout, spu_rst, busy, cmd_ready, off == 1, off == t_done,
                         off == t_to, off == t_to, exp_busy, !exp_busy);
            end
            tests++;
            if (pass) begin
                if ({mem_dm_addr, mem_dm_rd, mem_dm_wr, mem_dm_w_data} !==
                    {spu_dm_addr, spu_dm_rd, spu_dm_wr, spu_dm_w_data}) begin
                    fails++;
                    $display("FAIL run_passthru off=%0d got a=%h rd=%b wr=%b d=%h exp %h %b %b %h", off,
                             mem_dm_addr, mem_dm_rd, mem_dm_wr, mem_dm_w_data, spu_dm_addr, spu_dm_rd,
                             spu_dm_wr, spu_dm_w_data);
                end
                if (spu_dm_wr) ref_dm[spu_dm_addr] = spu_dm_w_data;
            end else if (bp && off == idle_off + 1) begin
                if ({mem_dm_wr, mem_dm_rd, mem_dm_addr, mem_dm_w_data} !== {2'b10, ba, bd}) begin
                    fails++;
                    $display("FAIL bp_write got wr=%b rd=%b a=%h d=%h exp 1 0 %h %h",
                             mem_dm_wr, mem_dm_rd, mem_dm_addr, mem_dm_w_data, ba, bd);
                end
            end else if ({mem_dm_rd, mem_dm_wr} !== 2'b00) begin
                fails++;
                $display("FAIL run_owned off=%0d got rd=%b wr=%b exp 0 0", off, mem_dm_rd, mem_dm_wr);
            end
            tick();
        end
        cmd_valid = 0; spu_dm_rd = 0; spu_dm_wr = 0; spu_stop = 1;
        if (bp) begin
            ref_dm[ba] = bd;
            tick(); tick();
            tests++;
            if (wr_count - wc0 !== 1) begin
                fails++;
                $display("FAIL bp_write_count got %0d exp 1", wr_count - wc0);
            end
        end
    endtask

    task automatic test_run();
        run_seq(22, 0);
        run_seq(3, 0);
        run_seq(int'($urandom_range(4, 40)), 0);
    endtask

    task automatic test_back_to_back();
        run_seq(15, 1);
    endtask

    task automatic test_reset_mid_read();
        cmd_valid = 1; cmd_op = 2'b11; cmd_addr = 8'($urandom_range(0, 7)); #1;
        tick();
        cmd_valid = 0; #1;
        tests++;
        if ({mem_dm_rd, busy} !== 2'b11) begin
            fails++;
            $display("FAIL rst_read_strobe got rd=%b busy=%b exp 1 1", mem_dm_rd, busy);
        end
        rst = 1;
        tick();
        rst = 0; #1;
        tests++;
        if ({rsp_valid, busy, cmd_ready, rsp_data} !== {3'b001, 16'h0}) begin
            fails++;
            $display("FAIL rst_read_after got rv=%b busy=%b rdy=%b data=%h exp 0 0 1 0000",
                     rsp_valid, busy, cmd_ready, rsp_data);
        end
        tick();
        tests++;
        if ({rsp_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL rst_read_later got rv=%b busy=%b exp 0 0", rsp_valid, busy);
        end
    endtask

`ifdef SPU_WDOG_EN
    task automatic test_watchdog();
        run_seq(0, 0);
        run_seq(W + 1, 0);
        run_seq(W + 2, 0);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL global_time_limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_dm[i] = '0;
        test_reset();
        test_im_write();
        test_dm_rw(16);
        test_run();
        test_back_to_back();
        test_dm_rw(12);
        test_reset_mid_read();
`ifdef SPU_WDOG_EN
        test_watchdog();
`endif
        test_dm_rw(6);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
